// File: rtl/dport_mailbox.sv
// dport_mailbox: memory-mapped mailbox on the core data port (mem_d_*).
// Four RW scratch words (RESULT0..3), a sticky first-write-wins STATUS word
// and a CYCLE word, answered in order after a fixed LATENCY, with optional
// periodic accept throttling (STALL_PERIOD).
// Optional feature macro: DPORT_MAILBOX_CYCLE_CNT_EN adds a free-running cycle
// counter behind CYCLE; RESULT3 writes latch a snapshot of it into CYCLE.
module dport_mailbox #(
    parameter logic [31:0] BASE_ADDR    = 32'h9000_0000,
    parameter int          LATENCY      = 2,
    parameter int          STALL_PERIOD = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_d_addr_i,
    input  logic [31:0] mem_d_data_wr_i,
    input  logic        mem_d_rd_i,
    input  logic [3:0]  mem_d_wr_i,
    input  logic        mem_d_cacheable_i,
    input  logic [10:0] mem_d_req_tag_i,
    input  logic        mem_d_invalidate_i,
    input  logic        mem_d_writeback_i,
    input  logic        mem_d_flush_i,
    output logic [31:0] mem_d_data_rd_o,
    output logic        mem_d_accept_o,
    output logic        mem_d_ack_o,
    output logic        mem_d_error_o,
    output logic [10:0] mem_d_resp_tag_o,
    output logic        done_o,
    output logic        pass_o,
    output logic [31:0] code_o
);
    localparam logic [31:0] STALL_LAST = (STALL_PERIOD == 0) ? 32'd0 : 32'(STALL_PERIOD - 1);

    logic [31:0]              stall_cnt_q, stall_cnt_d;
    logic [3:0][31:0]         result_q, result_d;
    logic                     done_q, done_d, pass_q, pass_d;
    logic [31:0]              code_q, code_d;
    logic [LATENCY-1:0]       pv_q, pv_d, perr_q, perr_d;
    logic [LATENCY-1:0][10:0] ptag_q, ptag_d;
    logic [LATENCY-1:0][31:0] pdata_q, pdata_d;
`ifdef DPORT_MAILBOX_CYCLE_CNT_EN
    logic [31:0]              cyc_cnt_q, cyc_cnt_d, cyc_snap_q, cyc_snap_d;
    logic                     snap_vld_q, snap_vld_d;
`endif

    logic        accept_s, maint_s, is_wr_s, is_rd_s, req_vld_s, taken_s;
    logic        in_win_s, dec_err_s, wr_ok_s;
    logic [5:0]  off_s;
    logic [31:0] rdata_s, cycle_rd_s;
    logic        unused_s;

    // Byte-offset bits and the cacheable hint carry no meaning here.
    assign unused_s = ^{mem_d_cacheable_i, mem_d_addr_i[1:0]};

    // Accept is low on the last count of each throttle period.
    assign accept_s = (STALL_PERIOD == 0) || (stall_cnt_q != STALL_LAST);

`ifdef DPORT_MAILBOX_CYCLE_CNT_EN
    assign cycle_rd_s = snap_vld_q ? cyc_snap_q : cyc_cnt_q;
`else
    assign cycle_rd_s = 32'd0;
`endif

    // Decode the presented request into read data and an error flag.
    always_comb begin
        maint_s   = mem_d_invalidate_i | mem_d_writeback_i | mem_d_flush_i;
        is_wr_s   = (mem_d_wr_i != 4'b0000);
        is_rd_s   = mem_d_rd_i;
        req_vld_s = is_rd_s | is_wr_s | maint_s;
        taken_s   = req_vld_s & accept_s;
        in_win_s  = (mem_d_addr_i[31:8] == BASE_ADDR[31:8]);
        off_s     = mem_d_addr_i[7:2];
        dec_err_s = 1'b0;
        rdata_s   = 32'd0;
        if (maint_s) begin
            // Maintenance ops win over any rd/wr presented alongside them.
            dec_err_s = 1'b0;
        end else if (!in_win_s || (is_rd_s && is_wr_s)) begin
            dec_err_s = 1'b1;
        end else begin
            case (off_s)
                6'd0, 6'd1, 6'd2, 6'd3: rdata_s = is_wr_s ? 32'd0 : result_q[off_s[1:0]];
                6'd4:    rdata_s = is_wr_s ? 32'd0 : {30'd0, pass_q, done_q};
                6'd5: begin
                    if (is_wr_s) begin
                        dec_err_s = 1'b1;
                    end else begin
                        rdata_s = cycle_rd_s;
                    end
                end
                default: dec_err_s = 1'b1;
            endcase
        end
        wr_ok_s = taken_s & ~maint_s & ~dec_err_s & is_wr_s;
    end

    // Register-file updates take effect at the accept edge.
    always_comb begin
        result_d = result_q;
        done_d   = done_q;
        pass_d   = pass_q;
        code_d   = code_q;
        if (wr_ok_s && (off_s < 6'd4)) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_d_wr_i[b]) begin
                    result_d[off_s[1:0]][8*b +: 8] = mem_d_data_wr_i[8*b +: 8];
                end else begin
                    result_d[off_s[1:0]][8*b +: 8] = result_q[off_s[1:0]][8*b +: 8];
                end
            end
        end else if (wr_ok_s && (off_s == 6'd4) && !done_q) begin
            // Only the first STATUS write counts; strobes are ignored.
            done_d = 1'b1;
            code_d = mem_d_data_wr_i;
            pass_d = (mem_d_data_wr_i == 32'd1);
        end else begin
            result_d = result_q;
        end
    end

`ifdef DPORT_MAILBOX_CYCLE_CNT_EN
    // Free-running counter; RESULT3 writes freeze a snapshot for CYCLE reads.
    always_comb begin
        cyc_cnt_d  = cyc_cnt_q + 32'd1;
        cyc_snap_d = cyc_snap_q;
        snap_vld_d = snap_vld_q;
        if (wr_ok_s && (off_s == 6'd3)) begin
            cyc_snap_d = cyc_cnt_q;
            snap_vld_d = 1'b1;
        end else begin
            snap_vld_d = snap_vld_q;
        end
    end
`endif

    // Throttle counter and fixed-latency response shift pipeline.
    always_comb begin
        if (STALL_PERIOD == 0) begin
            stall_cnt_d = 32'd0;
        end else if (stall_cnt_q == STALL_LAST) begin
            stall_cnt_d = 32'd0;
        end else begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        pv_d       = '0;
        perr_d     = '0;
        ptag_d     = '0;
        pdata_d    = '0;
        pv_d[0]    = taken_s;
        perr_d[0]  = taken_s & dec_err_s;
        ptag_d[0]  = taken_s ? mem_d_req_tag_i : 11'd0;
        pdata_d[0] = taken_s ? rdata_s : 32'd0;
        for (int i = 1; i < LATENCY; i++) begin
            pv_d[i]    = pv_q[i-1];
            perr_d[i]  = perr_q[i-1];
            ptag_d[i]  = ptag_q[i-1];
            pdata_d[i] = pdata_q[i-1];
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= 32'd0;
            result_q    <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            code_q      <= 32'd0;
            pv_q        <= '0;
            perr_q      <= '0;
            ptag_q      <= '0;
            pdata_q     <= '0;
`ifdef DPORT_MAILBOX_CYCLE_CNT_EN
            cyc_cnt_q   <= 32'd0;
            cyc_snap_q  <= 32'd0;
            snap_vld_q  <= 1'b0;
`endif
        end else begin
            stall_cnt_q <= stall_cnt_d;
            result_q    <= result_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            code_q      <= code_d;
            pv_q        <= pv_d;
            perr_q      <= perr_d;
            ptag_q      <= ptag_d;
            pdata_q     <= pdata_d;
`ifdef DPORT_MAILBOX_CYCLE_CNT_EN
            cyc_cnt_q   <= cyc_cnt_d;
            cyc_snap_q  <= cyc_snap_d;
            snap_vld_q  <= snap_vld_d;
`endif
        end
    end

    assign mem_d_accept_o   = accept_s;
    assign mem_d_ack_o      = pv_q[LATENCY-1];
    assign mem_d_error_o    = perr_q[LATENCY-1];
    assign mem_d_resp_tag_o = ptag_q[LATENCY-1];
    assign mem_d_data_rd_o  = pdata_q[LATENCY-1];
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign code_o           = code_q;
endmodule

// File: tb/tb_dport_mailbox.sv
// Scoreboard bench for dport_mailbox: driver pushes expected responses from a
// behavioural mailbox model; a monitor pops and compares on every ack.
`timescale 1ns/1ps
module tb_dport_mailbox;
    localparam logic [31:0] BASE = 32'h9000_0000;
    localparam int LAT = 2;
    localparam int SP  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr_i = 32'd0, wdata_i = 32'd0;
    logic        rd_i = 1'b0, cach_i = 1'b0, inv_i = 1'b0, wb_i = 1'b0, fl_i = 1'b0;
    logic [3:0]  wr_i = 4'd0;
    logic [10:0] tag_i = 11'd0;
    logic [31:0] rdata_o, code_o;
    logic        accept_o, ack_o, err_o, done_o, pass_o;
    logic [10:0] rtag_o;

    always #5 clk = ~clk;

    dport_mailbox #(.BASE_ADDR(BASE), .LATENCY(LAT), .STALL_PERIOD(SP)) dut (
        .clk(clk), .rst(rst),
        .mem_d_addr_i(addr_i), .mem_d_data_wr_i(wdata_i), .mem_d_rd_i(rd_i),
        .mem_d_wr_i(wr_i), .mem_d_cacheable_i(cach_i), .mem_d_req_tag_i(tag_i),
        .mem_d_invalidate_i(inv_i), .mem_d_writeback_i(wb_i), .mem_d_flush_i(fl_i),
        .mem_d_data_rd_o(rdata_o), .mem_d_accept_o(accept_o), .mem_d_ack_o(ack_o),
        .mem_d_error_o(err_o), .mem_d_resp_tag_o(rtag_o),
        .done_o(done_o), .pass_o(pass_o), .code_o(code_o)
    );

    typedef struct { logic [10:0] tag; logic [31:0] data; logic err; int cyc; } resp_t;
    resp_t exp_q[$];

    int checks = 0, failures = 0;
    int cyc = 0, since_rst = 0, ack_cnt = 0;
    bit live = 0;
    logic [10:0] next_tag = 11'd100;
    logic [31:0] last_data;
    logic        last_err;
    logic [10:0] last_tag;

    // Behavioural mailbox state
    logic [31:0] m_res [4];
    logic        m_done, m_pass, m_snap_vld;
    logic [31:0] m_code, m_snap;
    resp_t       mon_r;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_res[i] = 32'd0;
        m_done = 1'b0; m_pass = 1'b0; m_code = 32'd0; m_snap = 32'd0; m_snap_vld = 1'b0;
    endtask

    // Expected response from the mailbox rules; updates model state.
    task automatic model_apply(input logic [31:0] a, input logic [31:0] w, input logic rd,
                               input logic [3:0] wr, input logic [2:0] mt, input logic [10:0] tag,
                               input int tcyc, input int tcnt);
        resp_t r;
        int off;
        logic [23:0] base_hi;
        base_hi = BASE[31:8];
        r.tag = tag; r.data = 32'd0; r.err = 1'b0; r.cyc = tcyc;
        off = int'(a[7:2]);
        if (mt != 3'd0) begin
            r.err = 1'b0;
        end else if ((a[31:8] != base_hi) || (rd && (wr != 4'd0))) begin
            r.err = 1'b1;
        end else if (off < 4) begin
            if (wr != 4'd0) begin
                for (int b = 0; b < 4; b++)
                    if (wr[b]) m_res[off][8*b +: 8] = w[8*b +: 8];
            end else begin
                r.data = m_res[off];
            end
        end else if (off == 4) begin
            if (wr != 4'd0) begin
                if (!m_done) begin m_done = 1'b1; m_code = w; m_pass = (w == 32'd1); end
            end else begin
                r.data = {30'd0, m_pass, m_done};
            end
        end else if (off == 5) begin
            if (wr != 4'd0) r.err = 1'b1;
`ifdef DPORT_MAILBOX_CYCLE_CNT_EN
            else r.data = m_snap_vld ? m_snap : 32'(tcnt);
`endif
        end else begin
            r.err = 1'b1;
        end
`ifdef DPORT_MAILBOX_CYCLE_CNT_EN
        if ((mt == 3'd0) && !r.err && (wr != 4'd0) && (off == 3)) begin
            m_snap = 32'(tcnt); m_snap_vld = 1'b1;
        end
`endif
        exp_q.push_back(r);
    endtask

    task automatic drive_idle();
        addr_i = 32'd0; wdata_i = 32'd0; rd_i = 1'b0; wr_i = 4'd0;
        inv_i = 1'b0; wb_i = 1'b0; fl_i = 1'b0; tag_i = 11'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(negedge clk); drive_idle(); end
    endtask

    // Present one request and hold it until taken (bounded).
    task automatic issue(input logic [31:0] a, input logic [31:0] w, input logic rd,
                         input logic [3:0] wr, input logic [2:0] mt, input logic [10:0] tag);
        int n, tcyc, tcnt;
        n = 0;
        @(negedge clk);
        addr_i = a; wdata_i = w; rd_i = rd; wr_i = wr;
        inv_i = mt[0]; wb_i = mt[1]; fl_i = mt[2]; tag_i = tag;
        while (!accept_o && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) begin
            checks++; failures++;
            $display("FAIL accept_timeout: accept stayed %b, required 1", accept_o);
            drive_idle();
        end else begin
            tcyc = cyc; tcnt = since_rst;
            @(posedge clk);
            model_apply(a, w, rd, wr, mt, tag, tcyc, tcnt);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk); drive_idle();
        while (exp_q.size() != 0 && n < 40) begin @(negedge clk); n++; end
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
        end
    endtask

    // Cycle counters: absolute and since last reset edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) since_rst <= 0;
        else since_rst <= since_rst + 1;
    end

    // Monitor: compare every cycle, pop on each ack.
    always @(negedge clk) begin
        if (live) begin
            chk("accept", {31'd0, accept_o}, {31'd0, (since_rst % SP) != (SP - 1)});
            chk("done_o", {31'd0, done_o}, {31'd0, m_done});
            chk("pass_o", {31'd0, pass_o}, {31'd0, m_pass});
            chk("code_o", code_o, m_code);
            if (ack_o) begin
                ack_cnt++;
                last_data = rdata_o; last_err = err_o; last_tag = rtag_o;
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_ack: tag %h acked, required no ack", rtag_o);
                end else begin
                    mon_r = exp_q.pop_front();
                    chk("resp_tag", {21'd0, rtag_o}, {21'd0, mon_r.tag});
                    chk("resp_data", rdata_o, mon_r.data);
                    chk("resp_err", {31'd0, err_o}, {31'd0, mon_r.err});
                    chk("latency", 32'(cyc - mon_r.cyc), 32'(LAT));
                end
            end else begin
                chk("idle_data", rdata_o, 32'd0);
                chk("idle_tag", {21'd0, rtag_o}, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, required completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        int k, off, b0;
        logic [31:0] a;
        logic [3:0]  wr;
        logic        rd;
        logic [2:0]  mt;
        model_reset();
        drive_idle();
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1; live = 1;

        // Write then read RESULT0
        issue(BASE + 32'h00, 32'h3F, 1'b0, 4'hF, 3'd0, 11'd5);
        issue(BASE + 32'h00, 32'h0, 1'b1, 4'h0, 3'd0, 11'd6);
        drain();
        chk("t1_data", last_data, 32'h3F);
        chk("t1_tag", {21'd0, last_tag}, 32'd6);
        chk("t1_err", {31'd0, last_err}, 32'd0);

        // Byte-lane merge into RESULT1
        issue(BASE + 32'h04, 32'hAABBCCDD, 1'b0, 4'b0010, 3'd0, 11'd7);
        issue(BASE + 32'h05, 32'h0, 1'b1, 4'h0, 3'd0, 11'd8);
        drain();
        chk("byte_merge", last_data, 32'h0000CC00);

        // STATUS: first write wins
        issue(BASE + 32'h10, 32'd1, 1'b0, 4'h1, 3'd0, 11'd9);
        drain();
        chk("status_done", {31'd0, done_o}, 32'd1);
        chk("status_pass", {31'd0, pass_o}, 32'd1);
        chk("status_code", code_o, 32'd1);
        issue(BASE + 32'h10, 32'd7, 1'b0, 4'hF, 3'd0, 11'd10);
        issue(BASE + 32'h10, 32'd0, 1'b1, 4'h0, 3'd0, 11'd11);
        drain();
        chk("status_code_kept", code_o, 32'd1);
        chk("status_rd", last_data, 32'h3);

        // Unmapped and out-of-window reads
        issue(BASE + 32'h40, 32'd0, 1'b1, 4'h0, 3'd0, 11'd12);
        drain();
        chk("unmapped_err", {31'd0, last_err}, 32'd1);
        chk("unmapped_data", last_data, 32'd0);
        issue(32'h8000_0000, 32'd0, 1'b1, 4'h0, 3'd0, 11'd13);
        drain();
        chk("outwin_err", {31'd0, last_err}, 32'd1);

        // Maintenance op combined with a write has no effect
        issue(BASE + 32'h08, 32'hFFFF_FFFF, 1'b0, 4'hF, 3'b010, 11'd14);
        issue(BASE + 32'h08, 32'd0, 1'b1, 4'h0, 3'd0, 11'd15);
        drain();
        chk("maint_noeffect", last_data, 32'd0);

        // 12 back-to-back reads under throttling
        k = ack_cnt;
        for (int i = 0; i < 12; i++) issue(BASE + 32'h00, 32'd0, 1'b1, 4'h0, 3'd0, 11'(20 + i));
        drain();
        chk("b2b_acks", 32'(ack_cnt - k), 32'd12);

        // Reset with a response in flight and a request presented
        issue(BASE + 32'h0C, 32'hCAFE_F00D, 1'b0, 4'hF, 3'd0, 11'd40);
        @(negedge clk);
        addr_i = BASE + 32'h0C; rd_i = 1'b1; wr_i = 4'h0; tag_i = 11'd41; rst = 1'b0;
        @(posedge clk);
        exp_q.delete();
        model_reset();
        @(negedge clk); drive_idle();
        @(negedge clk); rst = 1'b1;
        idle(4);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        for (int i = 0; i < 4; i++) issue(BASE + 32'(4 * i), 32'd0, 1'b1, 4'h0, 3'd0, 11'(50 + i));
        drain();
        chk("rst_result3", last_data, 32'd0);

        // Randomised traffic
        for (int i = 0; i < 150; i++) begin
            off = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 6));
            b0  = int'($urandom_range(0, 3));
            a   = BASE + 32'(off * 4 + b0);
            if ($urandom_range(0, 9) == 0) a = $urandom();
            k = int'($urandom_range(0, 9));
            rd = 1'b0; wr = 4'h0; mt = 3'd0;
            if (k <= 4) rd = 1'b1;
            else if (k <= 7) wr = 4'($urandom_range(1, 15));
            else if (k == 8) begin rd = 1'b1; wr = 4'($urandom_range(1, 15)); end
            else begin
                mt = 3'($urandom_range(1, 7));
                rd = 1'($urandom_range(0, 1));
                wr = 4'($urandom_range(0, 15));
            end
            issue(a, $urandom(), rd, wr, mt, next_tag);
            next_tag = next_tag + 11'd1;
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dport_mailbox.md
Name: dport_mailbox

Overview:
- Memory-mapped responder on the riscv_core data port (mem_d_* interface); it is the responder end of the core's load/store initiator.
- Gives test programs a mailbox: four scratch result words plus a sticky DONE/PASS status word. Benches check completion by reading done_o/pass_o/code_o instead of decoding fetch PCs.
- Accepted requests are acked in order after a fixed, parameterised latency.
- Accept can be periodically throttled to exercise the core's data-port backpressure paths.

Parameters:
- BASE_ADDR, 32'h90000000, base of the 256-byte decode window; must be 256-byte aligned.
- LATENCY, 2, cycles from accept to ack; legal range 1..8.
- STALL_PERIOD, 0, accept_o is driven low for one cycle every STALL_PERIOD cycles; 0 disables throttling.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- mem_d_addr_i  in  32  request byte address
- mem_d_data_wr_i  in  32  write data
- mem_d_rd_i  in  1  read request
- mem_d_wr_i  in  4  byte write strobes
- mem_d_cacheable_i  in  1  ignored
- mem_d_req_tag_i  in  11  request tag, echoed on the response
- mem_d_invalidate_i  in  1  cache-maintenance request
- mem_d_writeback_i  in  1  cache-maintenance request
- mem_d_flush_i  in  1  cache-maintenance request
- mem_d_data_rd_o  out  32  read data, valid with ack
- mem_d_accept_o  out  1  request taken this cycle
- mem_d_ack_o  out  1  response valid, one-cycle pulse
- mem_d_error_o  out  1  error response, valid with ack
- mem_d_resp_tag_o  out  11  tag of the responding request
- done_o  out  1  STATUS has been written (sticky)
- pass_o  out  1  the STATUS write value was 1
- code_o  out  32  the STATUS write value

Behaviour:
- Request valid = rd_i | (wr_i != 0) | invalidate_i | writeback_i | flush_i.
- Request taken when valid & accept_o. The initiator holds the request until it is taken.
- Address map (in window when addr[31:8] == BASE_ADDR[31:8]; offset = addr[7:2]):
  - 0x00..0x0C: RESULT0..3, RW.
  - 0x10: STATUS, RW.
  - 0x14: CYCLE, RO.
  - All other offsets: unmapped.
- addr[1:0] is ignored.
- RESULTn write: byte-lane merge per wr_i bit.
- STATUS write, first only: done_q<=1, code_q<=data_wr_i, pass_q<=(data_wr_i==1).
  - Later STATUS writes are ignored until reset.
  - wr_i strobes are ignored for STATUS; the full word is taken.
- STATUS read returns {30'b0, pass_q, done_q}.
- Error response (error=1, data=0, no state change) for any of:
  - address outside the window;
  - unmapped offset;
  - write to CYCLE;
  - rd_i and wr_i!=0 together.
- Maintenance ops: acked with data=0, error=0, no state effect. If combined with rd_i or wr_i, only the maintenance op is acted on.
- Read data and write effects resolve at the accept cycle.
  - A read accepted after a write observes that write.
  - Back-to-back write/read to the same register is coherent.
- Response pipeline: LATENCY stages of {valid, tag, data, error}; it shifts every cycle.
  - Request taken at cycle N gives ack_o=1 at cycle N+LATENCY.
  - Acks are in order, exactly one per taken request.
  - Pipeline never blocks; throughput is one request per cycle.
- Throttle: stall_cnt counts 0..STALL_PERIOD-1; accept_o = (STALL_PERIOD==0) | (stall_cnt != STALL_PERIOD-1).
- Reset (rst==0 at a clk edge):
  - All outputs 0, except accept_o, which is 1 in the cycle after reset deassertion.
  - RESULTn=0, done/pass/code=0, CYCLE=0.
  - Pipeline cleared; in-flight responses are dropped, with no ack after reset.
- ack_o, error_o, resp_tag_o and data_rd_o are registered outputs.
- data_rd_o and resp_tag_o read 0 when ack_o=0.

Optional Feature:
- Macro: DPORT_MAILBOX_CYCLE_CNT_EN.
- Defined:
  - Free-running 32-bit cycle counter, counts from the first cycle out of reset and wraps 0xFFFFFFFF->0.
  - CYCLE reads return its value at the accept cycle.
  - Any write to RESULT3 latches counter snapshot into CYCLE instead (hold until next RESULT3 write); counter keeps running.
- Undefined:
  - No counter logic.
  - CYCLE reads return 0 with error=0.
  - Writes to CYCLE still error.

Test Plan:
- Write RESULT0=0x3F (wr=4'hF, tag=5), then read RESULT0 (tag=6), LATENCY=2 -> acks at accept+2 with tags 5 then 6; second ack has data=0x3F, error=0.
- Byte write wr=4'b0010 data 0xAABBCCDD to RESULT1 (initial 0) -> read returns 0x0000CC00.
- STATUS write 1, then STATUS write 7 -> done_o=1, pass_o=1, code_o=1 after the first write; unchanged after the second; STATUS read = 0x3.
- Read at BASE_ADDR+0x40, and a read outside the window at 0x80000000 -> both acked with error=1, data=0; no register changes.
- STALL_PERIOD=4, 12 back-to-back reads -> accept_o low every 4th cycle; 12 acks in tag order; none lost or duplicated.
- Assert rst with 2 requests in flight -> no ack after reset; RESULTn read 0; done_o=0. With the macro defined, CYCLE increments by 1 between consecutive reads one cycle apart.
